// File: rtl/c2h_frame_serializer.sv
// Serializes one wide simulation frame into a burst of AXI-Stream C2H beats.
// Owns the io_enable/data_next handshake upstream and tvalid/tready/tlast downstream.
module c2h_frame_serializer #(
    parameter int unsigned DATA_WIDTH = 16000,
    parameter int unsigned AXIS_WIDTH = 512
) (
    input  logic                      m_axis_c2h_aclk,
    input  logic                      rst_en,
    input  logic                      io_enable,
    input  logic [DATA_WIDTH-1:0]     io_data,
    output logic                      data_next,
    output logic [AXIS_WIDTH-1:0]     m_axis_c2h_tdata,
    output logic [AXIS_WIDTH/8-1:0]   m_axis_c2h_tkeep,
    output logic                      m_axis_c2h_tvalid,
    input  logic                      m_axis_c2h_tready,
    output logic                      m_axis_c2h_tlast,
    output logic [31:0]               frame_count
);

    localparam int unsigned NBEATS     = (DATA_WIDTH + AXIS_WIDTH - 1) / AXIS_WIDTH;
    localparam int unsigned LAST_BYTES = (DATA_WIDTH - (NBEATS - 1) * AXIS_WIDTH) / 8;
    localparam int unsigned KEEP_W     = AXIS_WIDTH / 8;
    localparam int unsigned PAD_W      = NBEATS * AXIS_WIDTH;
    localparam int unsigned BIDX_W     = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam logic [BIDX_W-1:0] LAST_IDX     = BIDX_W'(NBEATS - 1);
    localparam logic [BIDX_W-1:0] PRE_LAST_IDX = BIDX_W'((NBEATS > 1) ? NBEATS - 2 : 0);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t              state_q, state_d;
    logic [BIDX_W-1:0]   beat_idx_q, beat_idx_d;
    logic [PAD_W-1:0]    frame_q, frame_d;
    logic [AXIS_WIDTH-1:0] tdata_q, tdata_d;
    logic [KEEP_W-1:0]   tkeep_q, tkeep_d;
    logic                tvalid_q, tvalid_d;
    logic                tlast_q, tlast_d;
    logic                data_next_q, data_next_d;
    logic [31:0]         frame_count_q, frame_count_d;

    logic [PAD_W-1:0]    io_data_pad;
    logic [KEEP_W-1:0]   last_keep;

    always_comb begin
        io_data_pad = '0;
        io_data_pad[DATA_WIDTH-1:0] = io_data;
        last_keep = '0;
        for (int unsigned i = 0; i < KEEP_W; i++) begin
            last_keep[i] = (i < LAST_BYTES);
        end
    end

    // frame_q is a shift register holding the beats not yet presented, so the
    // next beat is always its low slice and no wide beat-select mux is needed.
    always_comb begin
        state_d       = state_q;
        beat_idx_d    = beat_idx_q;
        frame_d       = frame_q;
        tdata_d       = tdata_q;
        tkeep_d       = tkeep_q;
        tvalid_d      = tvalid_q;
        tlast_d       = tlast_q;
        data_next_d   = data_next_q;
        frame_count_d = frame_count_q;

        case (state_q)
            IDLE: begin
                data_next_d = 1'b1;
                tvalid_d    = 1'b0;
                if (io_enable && data_next_q) begin
                    state_d     = SEND;
                    beat_idx_d  = '0;
                    tdata_d     = io_data_pad[AXIS_WIDTH-1:0];
                    frame_d     = io_data_pad >> AXIS_WIDTH;
                    tkeep_d     = (NBEATS == 1) ? last_keep : '1;
                    tlast_d     = (NBEATS == 1);
                    tvalid_d    = 1'b1;
                    data_next_d = 1'b0;
                end
            end
            SEND: begin
                if (m_axis_c2h_tready) begin
                    if (beat_idx_q == LAST_IDX) begin
                        state_d       = IDLE;
                        beat_idx_d    = '0;
                        tdata_d       = '0;
                        tkeep_d       = '0;
                        tlast_d       = 1'b0;
                        tvalid_d      = 1'b0;
                        data_next_d   = 1'b1;
                        frame_count_d = frame_count_q + 32'd1;
                    end else begin
                        beat_idx_d = beat_idx_q + BIDX_W'(1);
                        tdata_d    = frame_q[AXIS_WIDTH-1:0];
                        frame_d    = frame_q >> AXIS_WIDTH;
                        tkeep_d    = (beat_idx_q == PRE_LAST_IDX) ? last_keep : '1;
                        tlast_d    = (beat_idx_q == PRE_LAST_IDX);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge m_axis_c2h_aclk or posedge rst_en) begin
        if (rst_en) begin
            state_q       <= IDLE;
            beat_idx_q    <= '0;
            frame_q       <= '0;
            tdata_q       <= '0;
            tkeep_q       <= '0;
            tvalid_q      <= 1'b0;
            tlast_q       <= 1'b0;
            data_next_q   <= 1'b0;
            frame_count_q <= '0;
        end else begin
            state_q       <= state_d;
            beat_idx_q    <= beat_idx_d;
            frame_q       <= frame_d;
            tdata_q       <= tdata_d;
            tkeep_q       <= tkeep_d;
            tvalid_q      <= tvalid_d;
            tlast_q       <= tlast_d;
            data_next_q   <= data_next_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign data_next         = data_next_q;
    assign m_axis_c2h_tdata  = tdata_q;
    assign m_axis_c2h_tkeep  = tkeep_q;
    assign m_axis_c2h_tvalid = tvalid_q;
    assign m_axis_c2h_tlast  = tlast_q;
    assign frame_count       = frame_count_q;

endmodule

// File: tb/tb_c2h_frame_serializer.sv
// Self-checking bench for c2h_frame_serializer: a queue-of-beats frame model
// checked every cycle, plus directed literal expectations.
module tb_c2h_frame_serializer;

    localparam int DW = 16000;
    localparam int AW = 512;
    localparam int KW = AW / 8;
    localparam int NB = 32;
    localparam int PW = NB * AW;
    localparam logic [KW-1:0] LAST_KEEP = 64'h0000_0000_0000_FFFF;
    localparam logic [KW-1:0] FULL_KEEP = {KW{1'b1}};

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          io_enable = 1'b0;
    logic          tready = 1'b0;
    logic [DW-1:0] io_data = '0;
    logic          data_next;
    logic [AW-1:0] tdata;
    logic [KW-1:0] tkeep;
    logic          tvalid;
    logic          tlast;
    logic [31:0]   frame_count;

    c2h_frame_serializer #(.DATA_WIDTH(DW), .AXIS_WIDTH(AW)) dut (
        .m_axis_c2h_aclk  (clk),
        .rst_en           (rst),
        .io_enable        (io_enable),
        .io_data          (io_data),
        .data_next        (data_next),
        .m_axis_c2h_tdata (tdata),
        .m_axis_c2h_tkeep (tkeep),
        .m_axis_c2h_tvalid(tvalid),
        .m_axis_c2h_tready(tready),
        .m_axis_c2h_tlast (tlast),
        .frame_count      (frame_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] d;
        logic [KW-1:0] k;
        logic          l;
    } beat_t;

    beat_t       exp_q[$];
    logic        exp_dn = 1'b0;
    int unsigned exp_cnt = 0;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] rx_q[$];
    bit          rec = 1'b0;

    task automatic chk(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // A captured frame becomes NBEATS queued beats, sliced straight from the payload.
    task automatic push_frame(input logic [DW-1:0] f);
        logic [PW-1:0] pad;
        beat_t b;
        pad = '0;
        pad[DW-1:0] = f;
        for (int k = 0; k < NB; k++) begin
            b.d = pad[k*AW +: AW];
            b.k = (k == NB - 1) ? LAST_KEEP : FULL_KEEP;
            b.l = (k == NB - 1);
            exp_q.push_back(b);
        end
    endtask

    // Model: idle/busy is just whether beats remain outstanding.
    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            exp_q.delete();
            exp_dn  = 1'b0;
            exp_cnt = 0;
        end else if (exp_q.size() != 0) begin
            if (tready) begin
                exp_q.delete(0);
                if (exp_q.size() == 0) begin
                    exp_cnt++;
                    exp_dn = 1'b1;
                end
            end
        end else if (exp_dn && io_enable) begin
            push_frame(io_data);
            exp_dn = 1'b0;
        end else begin
            exp_dn = 1'b1;
        end
    end

    initial forever begin
        @(negedge clk);
        if (rst) begin
            chk("rst_data_next", AW'(data_next), '0);
            chk("rst_tvalid", AW'(tvalid), '0);
            chk("rst_tlast", AW'(tlast), '0);
            chk("rst_tkeep", AW'(tkeep), '0);
            chk("rst_tdata", tdata, '0);
            chk("rst_frame_count", AW'(frame_count), '0);
        end else begin
            chk("data_next", AW'(data_next), AW'(exp_dn));
            chk("tvalid", AW'(tvalid), AW'(exp_q.size() != 0));
            chk("frame_count", AW'(frame_count), AW'(exp_cnt));
            if (exp_q.size() != 0) begin
                chk("tdata", tdata, exp_q[0].d);
                chk("tkeep", AW'(tkeep), AW'(exp_q[0].k));
                chk("tlast", AW'(tlast), AW'(exp_q[0].l));
                if (tready && rec) rx_q.push_back(tdata[31:0]);
            end else begin
                chk("idle_tlast", AW'(tlast), '0);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cyc;
        logic [31:0] w;

        // Reset held for 110 ns
        repeat (11) tick();
        rst = 1'b0;
        chk("dn_at_release", AW'(data_next), '0);
        tick();
        chk("dn_after_release", AW'(data_next), AW'(1));
        chk("count_after_release", AW'(frame_count), '0);

        // Single frame, io_data = 1
        io_data = '0;
        io_data[0] = 1'b1;
        io_enable = 1'b1;
        tready = 1'b1;
        tick();
        io_enable = 1'b0;
        chk("f1_tvalid", AW'(tvalid), AW'(1));
        chk("f1_dn_low", AW'(data_next), '0);
        chk("f1_beat0_tdata", tdata, AW'(1));
        chk("f1_beat0_tkeep", AW'(tkeep), AW'(FULL_KEEP));
        chk("f1_beat0_tlast", AW'(tlast), '0);
        repeat (31) tick();
        chk("f1_beat31_tlast", AW'(tlast), AW'(1));
        chk("f1_beat31_tkeep", AW'(tkeep), AW'(64'hFFFF));
        chk("f1_beat31_tdata", tdata, '0);
        tick();
        chk("f1_done_tvalid", AW'(tvalid), '0);
        chk("f1_done_dn", AW'(data_next), AW'(1));
        chk("f1_done_count", AW'(frame_count), AW'(1));

        // Backpressure, beat k carries k in its low word
        io_data = '0;
        for (int k = 0; k < NB; k++) io_data[k*AW +: 32] = 32'(k);
        io_enable = 1'b1;
        tick();
        io_enable = 1'b0;
        rx_q.delete();
        rec = 1'b1;
        cyc = 0;
        while (exp_cnt == 1 && cyc < 3000) begin
            tready = 1'($urandom_range(0, 1));
            tick();
            cyc++;
        end
        rec = 1'b0;
        tready = 1'b1;
        chk("bp_count", AW'(frame_count), AW'(2));
        chk("bp_nbeats", AW'(rx_q.size()), AW'(NB));
        for (int k = 0; k < NB; k++) begin
            w = (k < rx_q.size()) ? rx_q[k] : 32'hFFFF_FFFF;
            chk($sformatf("bp_order_%0d", k), AW'(w), AW'(k));
        end

        // io_enable held through SEND while io_data keeps changing
        io_data = '0;
        for (int k = 0; k < NB; k++) io_data[k*AW +: 32] = 32'hA500_0000 + 32'(k);
        io_enable = 1'b1;
        tick();
        chk("ign_beat0", AW'(tdata[31:0]), AW'(32'hA500_0000));
        for (int i = 0; i < 32; i++) begin
            for (int k = 0; k < DW / 32; k++) io_data[k*32 +: 32] = $urandom;
            tick();
            if (i == 4) chk("ign_beat5", AW'(tdata[31:0]), AW'(32'hA500_0005));
        end
        io_enable = 1'b0;
        chk("ign_count", AW'(frame_count), AW'(3));
        chk("ign_idle", AW'(tvalid), '0);
        tick();
        chk("ign_no_extra", AW'(tvalid), '0);

        // Mid-frame reset after beat 10 handshaken
        io_data = '0;
        for (int k = 0; k < NB; k++) io_data[k*AW +: 32] = 32'hB0 + 32'(k);
        io_enable = 1'b1;
        tick();
        io_enable = 1'b0;
        repeat (11) tick();
        chk("mid_beat11", AW'(tdata[31:0]), AW'(32'hBB));
        rst = 1'b1;
        #1;
        chk("mid_rst_tvalid", AW'(tvalid), '0);
        chk("mid_rst_count", AW'(frame_count), '0);
        chk("mid_rst_dn", AW'(data_next), '0);
        tick();
        repeat (2) tick();
        rst = 1'b0;
        tick();
        chk("mid_dn", AW'(data_next), AW'(1));
        io_data = '0;
        for (int k = 0; k < NB; k++) io_data[k*AW +: 32] = 32'hC0 + 32'(k);
        io_enable = 1'b1;
        tick();
        io_enable = 1'b0;
        chk("mid_new_beat0", AW'(tdata[31:0]), AW'(32'hC0));
        chk("mid_new_count", AW'(frame_count), '0);
        repeat (32) tick();
        chk("mid_new_done", AW'(frame_count), AW'(1));

        // Back-to-back: 20 frames, incrementing payload, tready held high
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        tick();
        io_enable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            io_data = '0;
            io_data[31:0] = 32'(i + 1);
            tick();
            chk($sformatf("b2b_beat0_%0d", i), AW'(tdata[31:0]), AW'(i + 1));
            chk($sformatf("b2b_count_%0d", i), AW'(frame_count), AW'(i));
            repeat (32) tick();
        end
        io_enable = 1'b0;
        chk("b2b_final_count", AW'(frame_count), AW'(20));
        chk("b2b_final_dn", AW'(data_next), AW'(1));
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/c2h_frame_serializer.md
# c2h_frame_serializer

Serializes one wide simulation frame (`io_data`, 16000 bits per frame) into a burst of AXI-Stream C2H beats for the XDMA card-to-host channel. It sits directly downstream of `simulation_top`'s frame producer and upstream of the DMA C2H stream port. It owns the `io_enable`/`data_next` handshake toward the producer and the `tvalid`/`tready`/`tlast` handshake toward the DMA.

## Interface
- `DATA_WIDTH`, 16000, frame width in bits; must be a multiple of 8.
- `AXIS_WIDTH`, 512, C2H stream width in bits.
- Derived: `NBEATS = ceil(DATA_WIDTH/AXIS_WIDTH)` (32); `LAST_BYTES = (DATA_WIDTH - (NBEATS-1)*AXIS_WIDTH)/8` (16).
- `m_axis_c2h_aclk  in  1`  single clock; all logic is on its rising edge.
- `rst_en  in  1`  asynchronous, active-high reset.
- `io_enable  in  1`  frame-valid qualifier; sampled only while `data_next`=1.
- `io_data  in  DATA_WIDTH`  frame payload; captured with `io_enable`.
- `data_next  out  1`  serializer is idle and can accept a frame.
- `m_axis_c2h_tdata  out  AXIS_WIDTH`  beat payload.
- `m_axis_c2h_tkeep  out  AXIS_WIDTH/8`  byte enables.
- `m_axis_c2h_tvalid  out  1`  beat valid.
- `m_axis_c2h_tready  in  1`  DMA accepts beat.
- `m_axis_c2h_tlast  out  1`  final beat of frame.
- `frame_count  out  32`  number of completed frames; wraps modulo 2^32.

## Operation
- FSM states:
  - IDLE: `data_next`=1, `tvalid`=0.
  - SEND: `data_next`=0, `tvalid`=1.
- IDLE→SEND: on a clock where `io_enable`=1 and `data_next`=1.
  - Capture `io_data` into the frame buffer.
  - Set `beat_idx`=0.
- `io_enable` while in SEND is ignored; no capture, no error. The producer may hold `io_enable` high across the whole frame.
- Beat mapping: beat k carries frame bits `[k*AXIS_WIDTH +: AXIS_WIDTH]`, LSB first.
  - Last-beat bits beyond `DATA_WIDTH` are driven 0.
- `tkeep`:
  - All ones for beats 0..NBEATS-2.
  - On beat NBEATS-1, the low `LAST_BYTES` bits are 1 and the rest 0 (0x0000_0000_0000_FFFF at defaults).
- `tlast`=1 only while `tvalid`=1 and `beat_idx`=NBEATS-1.
- A handshake (`tvalid`&`tready`) on a non-last beat increments `beat_idx`.
- A handshake on the last beat:
  - Returns the FSM to IDLE.
  - Increments `frame_count`.
  - Clears `beat_idx`.
- `tready`=0 holds `tdata`, `tkeep`, `tlast` and `tvalid` stable. `tvalid` never drops mid-frame.
- The captured frame buffer is immune to `io_data` changes until the next capture.
- `frame_count` wrap: 0xFFFF_FFFF + 1 = 0.
- Reset mid-frame aborts the frame. No partial-frame recovery; the DMA side sees a truncated packet without `tlast`.

## Timing
- Reset values (asserted asynchronously):
  - `data_next`=0, `tvalid`=0, `tlast`=0, `tkeep`=0, `tdata`=0.
  - `frame_count`=0, FSM=IDLE, `beat_idx`=0.
- `data_next` is registered. It rises on the first clock edge after `rst_en` deasserts.
- Capture edge N (`io_enable`&`data_next`):
  - `tvalid`=1 with beat 0 from N+1.
  - `data_next`=0 from N+1.
- With `tready` held 1, beats 0..NBEATS-1 appear on cycles N+1..N+NBEATS (32 cycles at defaults).
- Last handshake at edge M:
  - `tvalid`=0 and `data_next`=1 from M+1.
  - `frame_count` updated at M+1.
  - Earliest next capture is edge M+1; its beat 0 appears at M+2.
- Frame throughput with continuous `tready` is one frame per NBEATS+1 cycles.
- All outputs are registered. No combinational path from `tready` or `io_enable` to any output.

## Test plan
- Reset: hold `rst_en`=1 for 100 ns, then release.
  - All outputs are 0 during reset.
  - `data_next`=1 one clock after release.
  - `frame_count`=0.
- Single frame, `io_data`=1, `tready`=1:
  - 32 beats. Beat 0 `tdata`=1, beats 1..31 `tdata`=0.
  - `tlast` only on beat 31, with `tkeep`=0xFFFF on that beat and all-ones elsewhere.
  - `frame_count`=1, `data_next`=1 on the following cycle.
- Backpressure: random `tready` (~50%) over a frame whose word k = k.
  - Beats arrive in order 0..31 with no duplicates or drops.
  - Outputs are stable while `tready`=0.
- Ignored enable: hold `io_enable`=1 with changing `io_data` throughout SEND.
  - The transmitted frame equals the captured value.
  - No extra frame starts until IDLE.
- Mid-frame reset: assert `rst_en` after beat 10.
  - `tvalid`=0 immediately.
  - After release, a new frame serializes from beat 0 and `frame_count` restarts at 0.
- Back-to-back: drive the `simulation_top_tb` stimulus pattern for 20 frames.
  - `frame_count`=20.
  - Each frame's first beat low bits match the incrementing `io_data` value.
  - Gap between frames is exactly 1 idle cycle with `tready`=1.
